// File: rtl/uart_time_tx.sv
// UART 8N1 transmitter for the RTC host port.
// On a send request it snapshots the six BCD time digits and sends the frame "HH:MM:SS\r\n".
module uart_time_tx #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [3:0] h2,
  input  logic [3:0] h1,
  input  logic [3:0] m2,
  input  logic [3:0] m1,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned LAST_BYTE    = 9;
  localparam int unsigned LAST_BIT     = 7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [3:0]       byte_idx, byte_n;
  logic [23:0]      snap, snap_n;
  logic             tx_n, busy_n, done_n;
  logic             cnt_wrap;
  logic [7:0]       cur_char;

  // A BCD digit maps to its ASCII character; anything above 9 is shown as '?'.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + 8'(d)) : 8'h3F;
  endfunction

  // Character at a given frame position; snapshot layout is {h2,h1,m2,m1,s2,s1}.
  function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [23:0] t);
    case (idx)
      4'd0:    return digit_char(t[23:20]);
      4'd1:    return digit_char(t[19:16]);
      4'd3:    return digit_char(t[15:12]);
      4'd4:    return digit_char(t[11:8]);
      4'd6:    return digit_char(t[7:4]);
      4'd7:    return digit_char(t[3:0]);
      4'd2,
      4'd5:    return 8'h3A;
      4'd8:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      snap     <= snap_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next state and counters; outputs are derived from the next state so they register in step.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    snap_n   = snap;
    done_n   = 1'b0;
    tx_n     = 1'b1;
    busy_n   = 1'b0;
    cur_char = 8'h00;
    cnt_wrap = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    case (state)
      IDLE: begin
        if (send) begin
          snap_n  = {h2, h1, m2, m1, s2, s1};
          state_n = START;
          cnt_n   = '0;
          bit_n   = '0;
          byte_n  = '0;
        end
      end
      START: begin
        if (cnt_wrap) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          cnt_n = '0;
          if (bit_idx == 3'(LAST_BIT)) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_wrap) begin
          cnt_n = '0;
          if (byte_idx == 4'(LAST_BYTE)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            byte_n  = byte_idx + 4'd1;
            state_n = START;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    cur_char = frame_char(byte_n, snap_n);
    busy_n   = (state_n != IDLE);
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_char[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

endmodule
